// File: rtl/vga_pkg.sv
// vga_pkg
// Shared definitions for the VGA sprite renderer slice.
//   H_ACTIVE / V_ACTIVE : visible raster size the renderer is built for
//   COORD_W             : width of scan and sprite coordinates
//   COLOR_W_DEF         : default colour width (RGB332)
//   PIPE_LAT            : cycles from scan inputs to rgb/hsync/vsync
//   sprite_t            : one sprite slot {x, y, w, h, color, enable}
//   spanEnd()           : exclusive end of a sprite span, one bit wider than
//                         a coordinate so spans past 1023 clip instead of wrap
package vga_pkg;

    localparam int H_ACTIVE    = 640;
    localparam int V_ACTIVE    = 480;
    localparam int COORD_W     = 10;
    localparam int COLOR_W_DEF = 8;
    localparam int PIPE_LAT    = 2;

    typedef struct packed {
        logic [COORD_W-1:0]     x;
        logic [COORD_W-1:0]     y;
        logic [COORD_W-1:0]     w;
        logic [COORD_W-1:0]     h;
        logic [COLOR_W_DEF-1:0] color;
        logic                   enable;
    } sprite_t;

    function automatic logic [COORD_W:0] spanEnd(input logic [COORD_W-1:0] start,
                                                 input logic [COORD_W-1:0] len);
        return {1'b0, start} + {1'b0, len};
    endfunction

endpackage

// File: rtl/sprite_hit.sv
// sprite_hit
// Combinational window comparator for one sprite slot.
//   sprite_i : slot contents (only geometry and enable are used here)
//   x_i, y_i : current scan position
//   hit_o    : high when the slot is enabled and (x_i, y_i) lies inside it
module sprite_hit
    import vga_pkg::*;
(
    input  sprite_t            sprite_i,
    input  logic [COORD_W-1:0] x_i,
    input  logic [COORD_W-1:0] y_i,
    output logic               hit_o
);

    logic [COORD_W:0] xEnd;
    logic [COORD_W:0] yEnd;
    logic             inX;
    logic             inY;
    logic             unusedColor;

    // The colour travels in the same struct but is picked up by the top level.
    assign unusedColor = ^sprite_i.color;

    // End coordinates are one bit wider, so a sprite hanging off the right or
    // bottom edge is clipped and never wraps back to coordinate 0. A zero
    // width or height makes the window empty.
    always_comb begin
        xEnd  = spanEnd(sprite_i.x, sprite_i.w);
        yEnd  = spanEnd(sprite_i.y, sprite_i.h);
        inX   = (x_i >= sprite_i.x) && ({1'b0, x_i} < xEnd);
        inY   = (y_i >= sprite_i.y) && ({1'b0, y_i} < yEnd);
        hit_o = sprite_i.enable && inX && inY;
    end

endmodule

// File: rtl/vga_sprite_renderer.sv
// vga_sprite_renderer
// Pixel stage after the VGA sync generator: draws a bank of solid-colour
// rectangular sprites over a fixed background, two-cycle pipeline.
//   clk, rst                    : pixel clock, synchronous active-high reset
//   x, y, activeVideo           : scan position and visible-pixel flag
//   hsync_in, vsync_in          : raw active-low syncs, delayed to hsync/vsync
//   wr_valid/wr_ready, wr_*     : sprite write port (index >= NUM_SPRITES dropped)
//   rgb, hsync, vsync           : pixel colour and aligned syncs
// Build option VGA_SPRITE_SHADOW_EN: when defined, writes land in a shadow
// bank that is copied into the live bank the cycle after a vsync falling
// edge (wr_ready low for that cycle). When undefined, writes go straight to
// the live bank and wr_ready is high whenever not in reset.
module vga_sprite_renderer
    import vga_pkg::*;
#(
    parameter int                 NUM_SPRITES = 4,
    parameter int                 COLOR_W     = COLOR_W_DEF,
    parameter logic [COLOR_W-1:0] BG_COLOR    = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [9:0]         x,
    input  logic [9:0]         y,
    input  logic               activeVideo,
    input  logic               hsync_in,
    input  logic               vsync_in,
    input  logic               wr_valid,
    output logic               wr_ready,
    input  logic [2:0]         wr_index,
    input  logic [9:0]         wr_x,
    input  logic [9:0]         wr_y,
    input  logic [9:0]         wr_w,
    input  logic [9:0]         wr_h,
    input  logic [COLOR_W-1:0] wr_color,
    input  logic               wr_enable,
    output logic [COLOR_W-1:0] rgb,
    output logic               hsync,
    output logic               vsync
);

    sprite_t                  liveBank_q [NUM_SPRITES];
    sprite_t                  wrSprite;
    logic                     wrAccept;
    logic [NUM_SPRITES-1:0]   hit;
    logic [NUM_SPRITES-1:0]   hitS1_q;
    logic [COLOR_W-1:0]       colorS1_q [NUM_SPRITES];
    logic                     activeS1_q;
    logic [COLOR_W-1:0]       rgb_d;
    logic [COLOR_W-1:0]       rgb_q;
    logic [1:0]               hsyncDly_q;
    logic [1:0]               vsyncDly_q;

    // Pack the write-port fields into one slot image.
    always_comb begin
        wrSprite        = '0;
        wrSprite.x      = wr_x;
        wrSprite.y      = wr_y;
        wrSprite.w      = wr_w;
        wrSprite.h      = wr_h;
        wrSprite.color  = COLOR_W_DEF'(wr_color);
        wrSprite.enable = wr_enable;
    end

    assign wrAccept = wr_valid && wr_ready;

`ifdef VGA_SPRITE_SHADOW_EN
    sprite_t shadowBank_q [NUM_SPRITES];
    logic    vsyncPrev_q;
    logic    commit_q;
    logic    frameEnd;

    assign frameEnd = vsyncPrev_q && !vsync_in;
    assign wr_ready = !rst && !commit_q;

    // A registered vsync falling edge schedules the commit for the next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            vsyncPrev_q <= 1'b1;
            commit_q    <= 1'b0;
        end else begin
            vsyncPrev_q <= vsync_in;
            commit_q    <= frameEnd;
        end
    end

    // Writes only touch the shadow bank; the live bank is replaced as a whole
    // during the commit cycle, when wr_ready keeps writes out.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                liveBank_q[i]   <= '0;
                shadowBank_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                if (commit_q) begin
                    liveBank_q[i] <= shadowBank_q[i];
                end
                if (wrAccept && (wr_index == 3'(i))) begin
                    shadowBank_q[i] <= wrSprite;
                end
            end
        end
    end
`else
    assign wr_ready = !rst;

    // Single bank: writes land in the live bank and affect the next pixel.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                liveBank_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                if (wrAccept && (wr_index == 3'(i))) begin
                    liveBank_q[i] <= wrSprite;
                end
            end
        end
    end
`endif

    for (genvar g = 0; g < NUM_SPRITES; g++) begin : gHit
        sprite_hit u_hit (
            .sprite_i (liveBank_q[g]),
            .x_i      (x),
            .y_i      (y),
            .hit_o    (hit[g])
        );
    end

    // Stage 2 mux: scan from the lowest priority upward so slot 0 wins;
    // blanking overrides everything.
    always_comb begin
        rgb_d = BG_COLOR;
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            if (hitS1_q[i]) begin
                rgb_d = colorS1_q[i];
            end
        end
        if (!activeS1_q) begin
            rgb_d = '0;
        end
    end

    // Pipeline registers and matching sync delay line; reset loads blank values.
    always_ff @(posedge clk) begin
        if (rst) begin
            hitS1_q    <= '0;
            activeS1_q <= 1'b0;
            for (int i = 0; i < NUM_SPRITES; i++) begin
                colorS1_q[i] <= '0;
            end
            rgb_q      <= '0;
            hsyncDly_q <= 2'b11;
            vsyncDly_q <= 2'b11;
        end else begin
            hitS1_q    <= hit;
            activeS1_q <= activeVideo;
            for (int i = 0; i < NUM_SPRITES; i++) begin
                colorS1_q[i] <= COLOR_W'(liveBank_q[i].color);
            end
            rgb_q      <= rgb_d;
            hsyncDly_q <= {hsyncDly_q[0], hsync_in};
            vsyncDly_q <= {vsyncDly_q[0], vsync_in};
        end
    end

    assign rgb   = rgb_q;
    assign hsync = hsyncDly_q[1];
    assign vsync = vsyncDly_q[1];

endmodule

// File: tb/tb_vga_sprite_renderer.sv
// tb_vga_sprite_renderer
// Self-checking bench for vga_sprite_renderer: directed scenes followed by
// randomized pixels, writes and frame ends, all compared every cycle against
// a reference scene model (rectangles, priority, frame commit, 2-cycle delay).
// Follows VGA_SPRITE_SHADOW_EN the same way the design does.
module tb_vga_sprite_renderer;

    localparam int         NUM = 4;
    localparam logic [7:0] BG  = 8'h49;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] x;
    logic [9:0] y;
    logic       activeVideo;
    logic       hsync_in;
    logic       vsync_in;
    logic       wr_valid;
    logic       wr_ready;
    logic [2:0] wr_index;
    logic [9:0] wr_x;
    logic [9:0] wr_y;
    logic [9:0] wr_w;
    logic [9:0] wr_h;
    logic [7:0] wr_color;
    logic       wr_enable;
    logic [7:0] rgb;
    logic       hsync;
    logic       vsync;

    typedef struct {
        int x;
        int y;
        int w;
        int h;
        int c;
        bit en;
    } spr_t;

    spr_t mLive   [NUM];
    spr_t mShadow [NUM];
    bit   mVsPrev;
    bit   mCommit;
    int   expRgb1;
    int   expRgb2;
    bit   expHs1;
    bit   expHs2;
    bit   expVs1;
    bit   expVs2;
    int   total = 0;
    int   bad   = 0;

    vga_sprite_renderer #(
        .NUM_SPRITES (NUM),
        .COLOR_W     (8),
        .BG_COLOR    (BG)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .x           (x),
        .y           (y),
        .activeVideo (activeVideo),
        .hsync_in    (hsync_in),
        .vsync_in    (vsync_in),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_index    (wr_index),
        .wr_x        (wr_x),
        .wr_y        (wr_y),
        .wr_w        (wr_w),
        .wr_h        (wr_h),
        .wr_color    (wr_color),
        .wr_enable   (wr_enable),
        .rgb         (rgb),
        .hsync       (hsync),
        .vsync       (vsync)
    );

    always #5 clk = ~clk;

    // Colour of one pixel from the scene description: blank outside active
    // video, otherwise the first enabled rectangle containing it, else BG.
    function automatic int modelPixel(input int px, input int py, input bit av);
        if (!av) return 0;
        for (int i = 0; i < NUM; i++) begin
            if (mLive[i].en && px >= mLive[i].x && px < mLive[i].x + mLive[i].w &&
                py >= mLive[i].y && py < mLive[i].y + mLive[i].h)
                return mLive[i].c;
        end
        return int'(BG);
    endfunction

    task automatic checkOutput();
        total++;
        assert (rgb === 8'(expRgb2)) else begin
            bad++;
            $error("[TB] FAIL rgb got=%02h want=%02h at t=%0t", rgb, 8'(expRgb2), $time);
        end
        total++;
        assert (hsync === expHs2) else begin
            bad++;
            $error("[TB] FAIL hsync got=%0b want=%0b at t=%0t", hsync, expHs2, $time);
        end
        total++;
        assert (vsync === expVs2) else begin
            bad++;
            $error("[TB] FAIL vsync got=%0b want=%0b at t=%0t", vsync, expVs2, $time);
        end
    endtask

    // One pixel clock: check wr_ready, advance the model, clock, check outputs.
    task automatic applyStimulus();
        bit ready;
        bit accept;
        int idx;
        #1;
`ifdef VGA_SPRITE_SHADOW_EN
        ready = !rst && !mCommit;
`else
        ready = !rst;
`endif
        total++;
        assert (wr_ready === ready) else begin
            bad++;
            $error("[TB] FAIL wr_ready got=%0b want=%0b at t=%0t", wr_ready, ready, $time);
        end
        if (rst) begin
            for (int i = 0; i < NUM; i++) begin
                mLive[i]   = '{0, 0, 0, 0, 0, 1'b0};
                mShadow[i] = '{0, 0, 0, 0, 0, 1'b0};
            end
            mVsPrev = 1'b1;
            mCommit = 1'b0;
            expRgb1 = 0;  expRgb2 = 0;
            expHs1  = 1;  expHs2  = 1;
            expVs1  = 1;  expVs2  = 1;
        end else begin
            expRgb2 = expRgb1;
            expRgb1 = modelPixel(int'(x), int'(y), activeVideo);
            expHs2  = expHs1;  expHs1 = hsync_in;
            expVs2  = expVs1;  expVs1 = vsync_in;
            idx     = int'(wr_index);
            accept  = wr_valid && ready && idx < NUM;
`ifdef VGA_SPRITE_SHADOW_EN
            if (mCommit) begin
                for (int i = 0; i < NUM; i++) mLive[i] = mShadow[i];
            end
            if (accept)
                mShadow[idx] = '{int'(wr_x), int'(wr_y), int'(wr_w), int'(wr_h),
                                 int'(wr_color), wr_enable};
            mCommit = mVsPrev && !vsync_in;
            mVsPrev = vsync_in;
`else
            if (accept)
                mLive[idx] = '{int'(wr_x), int'(wr_y), int'(wr_w), int'(wr_h),
                               int'(wr_color), wr_enable};
`endif
        end
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    task automatic setPixel(input int px, input int py, input bit av);
        x           = 10'(px & 1023);
        y           = 10'(py & 1023);
        activeVideo = av;
        hsync_in    = 1'($urandom % 2);
    endtask

    task automatic setWrite(input int idx, input int sx, input int sy, input int sw,
                            input int sh, input int c, input bit en);
        wr_valid  = 1'b1;
        wr_index  = 3'(idx);
        wr_x      = 10'(sx);
        wr_y      = 10'(sy);
        wr_w      = 10'(sw);
        wr_h      = 10'(sh);
        wr_color  = 8'(c);
        wr_enable = en;
    endtask

    task automatic randomPixel();
        int k;
        int px;
        int py;
        k = int'($urandom_range(0, NUM - 1));
        if ($urandom % 2 == 0) begin
            px = mLive[k].x + int'($urandom_range(0, 4 + (mLive[k].w % 64))) - 2;
            py = mLive[k].y + int'($urandom_range(0, 4 + (mLive[k].h % 64))) - 2;
        end else begin
            px = int'($urandom % 1024);
            py = int'($urandom % 1024);
        end
        setPixel(px, py, ($urandom % 8) != 0);
    endtask

    task automatic scanRow(input int py, input int xs, input int xe, input bit av);
        wr_valid = 1'b0;
        for (int px = xs; px <= xe; px++) begin
            setPixel(px, py, av);
            applyStimulus();
        end
    endtask

    task automatic frameEnd();
        wr_valid = 1'b0;
        vsync_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            setPixel(int'($urandom % 1024), 490, 1'b0);
            applyStimulus();
        end
        vsync_in = 1'b1;
    endtask

    initial begin
        rst = 1'b1;  x = '0;  y = '0;  activeVideo = 1'b0;
        hsync_in = 1'b0;  vsync_in = 1'b0;
        wr_valid = 1'b0;  wr_index = '0;  wr_x = '0;  wr_y = '0;
        wr_w = '0;  wr_h = '0;  wr_color = '0;  wr_enable = 1'b0;
        mVsPrev = 1'b1;  mCommit = 1'b0;
        expRgb1 = 0;  expRgb2 = 0;  expHs1 = 1;  expHs2 = 1;  expVs1 = 1;  expVs2 = 1;

        // Reset mid-line with syncs low: blank outputs, wr_ready low.
        $display("[TB] reset");
        for (int i = 0; i < 3; i++) begin
            setPixel(10 + i, 20, 1'b1);
            hsync_in = 1'b0;
            applyStimulus();
        end
        vsync_in = 1'b1;
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            setPixel(int'($urandom % 640), int'($urandom % 480), 1'b1);
            applyStimulus();
        end

        // Single sprite: invisible in the current frame, exact box in the next.
        $display("[TB] single sprite");
        setWrite(0, 100, 50, 20, 10, 8'hE0, 1'b1);
        setPixel(105, 55, 1'b1);
        applyStimulus();
        scanRow(55, 96, 123, 1'b1);
        frameEnd();
        scanRow(49, 98, 121, 1'b1);
        scanRow(50, 98, 121, 1'b1);
        scanRow(59, 98, 121, 1'b1);
        scanRow(60, 98, 121, 1'b1);
        scanRow(55, 98, 121, 1'b0);

        // Priority and right-edge clipping.
        $display("[TB] priority and clip");
        setWrite(0, 1010, 200, 20, 10, 8'h1C, 1'b1);
        setPixel(0, 0, 1'b1);
        applyStimulus();
        setWrite(2, 1005, 195, 20, 20, 8'h03, 1'b1);
        applyStimulus();
        frameEnd();
        scanRow(200, 1000, 1023, 1'b1);
        scanRow(200, 0, 5, 1'b1);
        scanRow(196, 1003, 1023, 1'b1);

        // Write held across the commit cycle lands in shadow only.
        $display("[TB] shadow overlap");
        setPixel(310, 102, 1'b1);
        vsync_in = 1'b0;
        applyStimulus();
        setWrite(1, 300, 100, 30, 5, 8'hFC, 1'b1);
        for (int i = 0; i < 3; i++) begin
            setPixel(305 + i, 102, 1'b0);
            applyStimulus();
        end
        vsync_in = 1'b1;
        scanRow(102, 297, 333, 1'b1);
        frameEnd();
        scanRow(102, 297, 333, 1'b1);

        // Zero-width slot and out-of-range index change nothing visible.
        $display("[TB] edge cases");
        setWrite(3, 400, 300, 0, 8, 8'hFF, 1'b1);
        setPixel(400, 300, 1'b1);
        applyStimulus();
        setWrite(7, 400, 300, 10, 8, 8'hAA, 1'b1);
        applyStimulus();
        frameEnd();
        scanRow(303, 397, 412, 1'b1);

        // Randomized scenes, writes, frame ends and one reset.
        $display("[TB] random");
        for (int n = 0; n < 3000; n++) begin
            randomPixel();
            wr_valid = ($urandom % 6) == 0;
            wr_index = 3'($urandom % 8);
            wr_x     = 10'($urandom % 1024);
            wr_y     = 10'($urandom % 1024);
            wr_w     = ($urandom % 8 == 0) ? 10'($urandom % 1024) : 10'($urandom % 48);
            wr_h     = ($urandom % 8 == 0) ? 10'($urandom % 1024) : 10'($urandom % 48);
            wr_color = 8'($urandom);
            wr_enable = ($urandom % 4) != 0;
            vsync_in = !((n % 150) >= 146);
            rst      = (n >= 1500 && n < 1502);
            applyStimulus();
        end
        rst = 1'b0;
        wr_valid = 1'b0;
        vsync_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            randomPixel();
            applyStimulus();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vga_sprite_renderer.md
# vga_sprite_renderer

Pixel-generation stage directly downstream of the VGA sync generator. Consumes the scan position, `activeVideo` and raw sync strobes, and produces one colour per pixel clock. The colour is drawn from a small bank of solid-colour rectangular sprites over a fixed background. Sync outputs are delayed to stay aligned with the pipelined colour. Sprites are programmed through a valid/ready write port and, by default, committed only at frame boundaries so no frame shows a half-updated scene.

## Interface
- `NUM_SPRITES`, 4: number of sprite slots, 1..8; index 0 has highest priority.
- `COLOR_W`, 8: colour width (RGB332).
- `BG_COLOR`, 8'h00: colour for active pixels not covered by any enabled sprite.

Ports:
- `clk` in 1: pixel clock.
- `rst` in 1: reset, synchronous to `clk`, active-high.
- `x` in 10: horizontal scan position.
- `y` in 10: vertical scan position.
- `activeVideo` in 1: high when (`x`, `y`) is a visible pixel.
- `hsync_in` in 1: horizontal sync, active-low.
- `vsync_in` in 1: vertical sync, active-low.
- `wr_valid` in 1: sprite write request.
- `wr_ready` out 1: write accepted when `wr_valid && wr_ready` at a rising edge.
- `wr_index` in 3: target slot; values ≥ `NUM_SPRITES` are accepted and discarded.
- `wr_x` in 10: left edge.
- `wr_y` in 10: top edge.
- `wr_w` in 10: width in pixels.
- `wr_h` in 10: height in pixels.
- `wr_color` in `COLOR_W`: fill colour.
- `wr_enable` in 1: slot visible.
- `rgb` out `COLOR_W`: pixel colour.
- `hsync` out 1: `hsync_in` delayed to match `rgb`.
- `vsync` out 1: `vsync_in` delayed to match `rgb`.

## Operation
- **Sprite registers.** Each slot holds {x, y, w, h, color, enable}.
  - The live bank drives rendering.
  - The shadow bank receives writes (see Configuration).
- **Hit test, per slot.** A slot hits when all of the following hold:
  - enable = 1;
  - `x` ≥ sx and `x` < sx + w;
  - `y` ≥ sy and `y` < sy + h.
- **Hit arithmetic.** Sums are computed at 11 bits, so sprites overhanging past 1023 clip rather than wrap. w = 0 or h = 0 never hits.
- **Priority.** The lowest-index hitting slot supplies the colour. With no hit, the colour is `BG_COLOR`.
- **Blanking.** When `activeVideo` = 0, `rgb` = 0 regardless of sprites.
- **Frame-end detect.** `vsync_in` is registered; a 1→0 transition marks frame end.
- **Commit.** In the cycle after frame end is detected, the shadow bank is copied whole into the live bank, and `wr_ready` is 0 for that cycle.
- **Writes.**
  - An accepted write updates exactly one shadow slot with all six fields.
  - Back-to-back writes are accepted at one per cycle.
  - A write to slot k in the same cycle as commit cannot occur, because `wr_ready` is 0.
- **Reset.** Both banks are cleared: all fields 0, enable 0.

## Timing
- **Latency.** Two cycles from inputs to `rgb`/`hsync`/`vsync`.
  - Stage 1 registers per-slot hits, slot colours and `activeVideo`.
  - Stage 2 registers the priority-mux result.
  - `hsync_in`/`vsync_in` pass through a matching 2-deep delay line.
- **Reset values.** While `rst` is high and on the first edge after it falls:
  - `rgb` = 0, `hsync` = 1, `vsync` = 1;
  - `wr_ready` = 0 during reset, then 1 from the first cycle after `rst` falls;
  - pipeline and delay-line registers are loaded with the same blank values.
- **Reset mid-frame.** Outputs reach their blank values at the first edge with `rst` high. Normal output resumes 2 cycles after release.
- **Commit visibility.** A write accepted before frame end is visible from the first active pixel of the next frame. A write accepted after the commit cycle waits one more frame.
- **Write/commit overlap.** A write held with `wr_valid` across the commit cycle is accepted on the following cycle, into shadow only.

## Configuration
- `VGA_SPRITE_SHADOW_EN` defined (default build):
  - double-buffered shadow/live banks;
  - commit at frame end;
  - `wr_ready` drops for the commit cycle.
- `VGA_SPRITE_SHADOW_EN` undefined:
  - single bank; writes go directly to the live bank and take effect for pixels entering stage 1 on the next cycle;
  - `wr_ready` = 1 whenever not in reset;
  - frame-end detect and commit logic are removed.

## Structure
- **Package `vga_pkg`:**
  - constants H_ACTIVE = 640, V_ACTIVE = 480;
  - coordinate width 10 and colour width default;
  - packed struct `sprite_t` {x, y, w, h, color, enable};
  - pipeline depth constant PIPE_LAT = 2.
- **Sub-module `sprite_hit`:** combinational window comparator for one slot, taking `sprite_t` plus `x`/`y` and returning hit. Instantiated `NUM_SPRITES` times in a generate loop. All registers stay in `vga_sprite_renderer`.

## Test plan
- **Reset:** hold `rst` for 3 cycles mid-line → `rgb` = 0, `hsync` = `vsync` = 1, `wr_ready` = 0; after release, `wr_ready` = 1 and `rgb` = `BG_COLOR` on active pixels 2 cycles later.
- **Single sprite:** write slot 0 {x 100, y 50, w 20, h 10, color 8'hE0, en 1}, then let a frame end → in the next frame, `rgb` = E0 exactly for x 100..119 on y 50..59, `BG_COLOR` elsewhere, 2-cycle offset from inputs; `hsync`/`vsync` equal the inputs delayed by 2.
- **Priority and clip:** overlap slot 0 (color 1C) and slot 2 (color 03) at x 1010, w 20 → overlap shows 1C; no wrap-around hit at x 0..5.
- **Shadow:** write slot 1 mid-frame → no change in the current frame; change appears in the next; `wr_ready` is 0 for exactly one cycle after the vsync fall, and a held write is accepted on the next cycle.
- **Edge cases:** w = 0 slot and `wr_index` = 7 with `NUM_SPRITES` = 4 → no visible change; with `activeVideo` = 0, `rgb` = 0 even inside a sprite.
- **Unshadowed build:** rebuild without `VGA_SPRITE_SHADOW_EN`, write mid-line → colour changes 3 cycles after the accepted write; `wr_ready` is constantly 1.
